// File: rtl/load_store_unit_if.sv
// Core-request, response and data-memory signals of the load/store unit.
// The unit is the slave; the core/memory side is the master.
interface load_store_unit_if #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TRANSFER_WIDTH = 4
);
   logic                      req_valid_i;
   logic                      req_ready_o;
   logic                      req_we_i;
   logic [2:0]                req_funct3_i;
   logic [ADDR_WIDTH-1:0]     req_addr_i;
   logic [DATA_WIDTH-1:0]     req_wdata_i;
   logic                      rsp_valid_o;
   logic [DATA_WIDTH-1:0]     rsp_rdata_o;
   logic                      rsp_err_o;
   logic [ADDR_WIDTH-1:0]     mem_addr_o;
   logic                      mem_we_o;
   logic [DATA_WIDTH-1:0]     mem_wdata_o;
   logic [TRANSFER_WIDTH-1:0] mem_transfer_o;
   logic [DATA_WIDTH-1:0]     mem_rdata_i;

   modport slave (
      input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
             mem_addr_o, mem_we_o, mem_wdata_o, mem_transfer_o
   );

   modport master (
      output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
             mem_addr_o, mem_we_o, mem_wdata_o, mem_transfer_o
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request in flight, response 2 cycles after accept (1 for errors,
// 3 for word-crossing accesses when LSU_MISALIGNED_SPLIT_EN is defined); ready only when idle.
module load_store_unit #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TRANSFER_WIDTH = 4
) (
   input logic              clk,
   input logic              rst_n,
   load_store_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

   state_t                  state, state_nxt;
   logic                    we_q, err_q;
   logic [2:0]              f3_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q, rdata_q, rdata_nxt;
   logic                    rdata_en;
   logic                    ill_in, mis_in, err_in;
   logic [TRANSFER_WIDTH-1:0]   base_mask;
   logic [2*TRANSFER_WIDTH-1:0] lane_wide;
   logic [5:0]              sh_lo;
   logic [ADDR_WIDTH-1:0]   word_addr;

   function automatic logic [DATA_WIDTH-1:0] extend(input logic [2:0] f3,
                                                    input logic [DATA_WIDTH-1:0] x);
      case (f3)
         3'd0:    extend = {{24{x[7]}}, x[7:0]};
         3'd1:    extend = {{16{x[15]}}, x[15:0]};
         3'd4:    extend = {24'b0, x[7:0]};
         3'd5:    extend = {16'b0, x[15:0]};
         default: extend = x;
      endcase
   endfunction

   assign ill_in = bus.req_we_i ? (bus.req_funct3_i >= 3'd3)
                                : (bus.req_funct3_i == 3'd3 || bus.req_funct3_i >= 3'd6);
   assign mis_in = (bus.req_funct3_i[1:0] == 2'd1) ? (bus.req_addr_i[1:0] == 2'd3)
                 : (bus.req_funct3_i[1:0] == 2'd2) ? (bus.req_addr_i[1:0] != 2'd0) : 1'b0;

`ifdef LSU_MISALIGNED_SPLIT_EN
   logic [DATA_WIDTH-1:0] lo_q;
   logic [5:0]            sh_hi;
   logic                  mis_q;
   assign err_in = ill_in;
   assign sh_hi  = 6'd32 - sh_lo;
   assign mis_q  = (f3_q[1:0] == 2'd1) ? (addr_q[1:0] == 2'd3)
                 : (f3_q[1:0] == 2'd2) ? (addr_q[1:0] != 2'd0) : 1'b0;
`else
   assign err_in = ill_in | mis_in;
`endif

   always_comb begin
      case (f3_q[1:0])
         2'd0:    base_mask = TRANSFER_WIDTH'(4'b0001);
         2'd1:    base_mask = TRANSFER_WIDTH'(4'b0011);
         default: base_mask = TRANSFER_WIDTH'(4'b1111);
      endcase
   end

   // Lanes pushed past bit 3 belong to the following word.
   assign lane_wide = {{TRANSFER_WIDTH{1'b0}}, base_mask} << addr_q[1:0];
   assign sh_lo     = {1'b0, addr_q[1:0], 3'b000};
   assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

   always_comb begin
      state_nxt          = state;
      bus.req_ready_o    = 1'b0;
      bus.rsp_valid_o    = 1'b0;
      bus.rsp_err_o      = 1'b0;
      bus.mem_addr_o     = '0;
      bus.mem_we_o       = 1'b0;
      bus.mem_wdata_o    = '0;
      bus.mem_transfer_o = '0;
      rdata_en           = 1'b0;
      rdata_nxt          = '0;
      case (state)
         IDLE: begin
            bus.req_ready_o = 1'b1;
            if (bus.req_valid_i) begin
               if (err_in) begin
                  state_nxt = RESP;
                  rdata_en  = 1'b1;
               end else begin
                  state_nxt = ACC1;
               end
            end
         end
         ACC1: begin
            bus.mem_addr_o     = word_addr;
            bus.mem_we_o       = we_q;
            bus.mem_transfer_o = lane_wide[TRANSFER_WIDTH-1:0];
            bus.mem_wdata_o    = wdata_q << sh_lo;
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (mis_q) begin
               state_nxt = ACC2;
            end else
`endif
            begin
               state_nxt = RESP;
               rdata_en  = 1'b1;
               rdata_nxt = we_q ? '0 : extend(f3_q, bus.mem_rdata_i >> sh_lo);
            end
         end
`ifdef LSU_MISALIGNED_SPLIT_EN
         ACC2: begin
            bus.mem_addr_o     = word_addr + ADDR_WIDTH'(4);
            bus.mem_we_o       = we_q;
            bus.mem_transfer_o = lane_wide[2*TRANSFER_WIDTH-1:TRANSFER_WIDTH];
            bus.mem_wdata_o    = wdata_q >> sh_hi;
            state_nxt          = RESP;
            rdata_en           = 1'b1;
            rdata_nxt          = we_q ? '0 : extend(f3_q, lo_q | (bus.mem_rdata_i << sh_hi));
         end
`endif
         RESP: begin
            bus.rsp_valid_o = 1'b1;
            bus.rsp_err_o   = err_q;
            state_nxt       = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.rsp_rdata_o = rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && bus.req_valid_i) begin
            we_q    <= bus.req_we_i;
            err_q   <= err_in;
            f3_q    <= bus.req_funct3_i;
            addr_q  <= bus.req_addr_i;
            wdata_q <= bus.req_wdata_i;
         end
         if (rdata_en) rdata_q <= rdata_nxt;
      end
   end

`ifdef LSU_MISALIGNED_SPLIT_EN
   // Low part of a split load: first-word bytes already moved to the bottom.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             lo_q <= '0;
      else if (state == ACC1) lo_q <= bus.mem_rdata_i >> sh_lo;
   end
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// Load/store unit bench: byte-addressed reference memory and per-cycle checks of the
// memory port and response timing, directed cases followed by random requests.
module tb_load_store_unit;
`ifdef LSU_MISALIGNED_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   load_store_unit_if bus ();
   load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [31:0] mem [64];
   logic [7:0]  ref_b [256];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] last_rdata = 32'h0;
   logic [31:0] rd;

   assign bus.mem_rdata_i = mem[bus.mem_addr_o[7:2]];

   always @(posedge clk) begin
      if (bus.mem_we_o)
         for (int k = 0; k < 4; k++)
            if (bus.mem_transfer_o[k])
               mem[bus.mem_addr_o[7:2]][8*k +: 8] <= bus.mem_wdata_o[8*k +: 8];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rsp);
      int          n, nacc;
      bit          ill, crosses, err;
      longint      v;
      logic [31:0] exp_rd, wb, ba, dexp, dmask;
      logic [3:0]  strb;
      n       = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      ill     = we ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 >= 3'd6);
      crosses = (int'(a[1:0]) + n) > 4;
      nacc    = ill ? 0 : crosses ? (SPLIT ? 2 : 0) : 1;
      err     = (nacc == 0);
      exp_rd  = 32'h0;
      if (!we && !err) begin
         v = 0;
         for (int i = 0; i < n; i++) v |= longint'(ref_b[8'(a + 32'(i))]) << (8 * i);
         if (!f3[2] && n < 4 && v[8*n-1]) v -= (longint'(1) << (8 * n));
         exp_rd = v[31:0];
      end

      @(negedge clk);
      check("ready_idle", 32'(bus.req_ready_o), 32'h1);
      check("valid_idle", 32'(bus.rsp_valid_o), 32'h0);
      bus.req_valid_i  = 1'b1;
      bus.req_we_i     = we;
      bus.req_funct3_i = f3;
      bus.req_addr_i   = a;
      bus.req_wdata_i  = wd;
      rsp = 32'hx;
      for (int cyc = 1; cyc <= nacc + 1; cyc++) begin
         @(negedge clk);
         bus.req_valid_i = 1'b0;
         check("ready_busy", 32'(bus.req_ready_o), 32'h0);
         if (cyc <= nacc) begin
            wb    = {a[31:2], 2'b00} + 32'(4 * (cyc - 1));
            strb  = 4'h0;
            dexp  = 32'h0;
            dmask = 32'h0;
            for (int i = 0; i < n; i++) begin
               ba = a + 32'(i);
               if ({ba[31:2], 2'b00} == wb) begin
                  strb[ba[1:0]]          = 1'b1;
                  dexp[8*ba[1:0] +: 8]   = wd[8*i +: 8];
                  dmask[8*ba[1:0] +: 8]  = 8'hFF;
               end
            end
            check("mem_addr", bus.mem_addr_o, wb);
            check("mem_we", 32'(bus.mem_we_o), 32'(we));
            check("mem_strobe", 32'(bus.mem_transfer_o), 32'(strb));
            if (we) check("mem_wdata", bus.mem_wdata_o & dmask, dexp);
            check("valid_early", 32'(bus.rsp_valid_o), 32'h0);
            check("rdata_held", bus.rsp_rdata_o, last_rdata);
         end else begin
            check("rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
            check("rsp_err", 32'(bus.rsp_err_o), 32'(err));
            check("rsp_rdata", bus.rsp_rdata_o, exp_rd);
            check("resp_mem_idle", {bus.mem_addr_o[29:0], bus.mem_we_o, |bus.mem_transfer_o}, 32'h0);
            rsp = bus.rsp_rdata_o;
         end
      end
      last_rdata = exp_rd;
      if (we && !err)
         for (int i = 0; i < n; i++) ref_b[8'(a + 32'(i))] = wd[8*i +: 8];
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      bus.req_valid_i  = 1'b0;
      bus.req_we_i     = 1'b0;
      bus.req_funct3_i = 3'd0;
      bus.req_addr_i   = 32'h0;
      bus.req_wdata_i  = 32'h0;
      for (int i = 0; i < 64; i++) begin
         w = $urandom;
         mem[i] = w;
         for (int k = 0; k < 4; k++) ref_b[4*i + k] = w[8*k +: 8];
      end

      @(negedge clk);
      check("rst_ready", 32'(bus.req_ready_o), 32'h1);
      check("rst_valid", 32'(bus.rsp_valid_o), 32'h0);
      check("rst_err", 32'(bus.rsp_err_o), 32'h0);
      check("rst_rdata", bus.rsp_rdata_o, 32'h0);
      check("rst_mem", bus.mem_addr_o | bus.mem_wdata_o | 32'(bus.mem_transfer_o) | 32'(bus.mem_we_o), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Byte store into the top lane
      do_req(1'b1, 3'd0, 32'h0000_0013, 32'h0000_00AB, rd);

      // Sign/zero extension of bytes and halfwords
      do_req(1'b1, 3'd2, 32'h0000_0020, 32'h8000_FF7F, rd);
      do_req(1'b0, 3'd0, 32'h0000_0020, 32'h0, rd);  check("lb_20", rd, 32'h0000_007F);
      do_req(1'b0, 3'd0, 32'h0000_0021, 32'h0, rd);  check("lb_21", rd, 32'hFFFF_FFFF);
      do_req(1'b0, 3'd5, 32'h0000_0022, 32'h0, rd);  check("lhu_22", rd, 32'h0000_8000);
      do_req(1'b0, 3'd1, 32'h0000_0022, 32'h0, rd);  check("lh_22", rd, 32'hFFFF_8000);
      do_req(1'b0, 3'd3, 32'h0000_0020, 32'h0, rd);  check("ld_f3_3", rd, 32'h0);

`ifdef LSU_MISALIGNED_SPLIT_EN
      do_req(1'b1, 3'd2, 32'h0000_0040, 32'h4433_2211, rd);
      do_req(1'b1, 3'd2, 32'h0000_0044, 32'h8877_6655, rd);
      do_req(1'b0, 3'd2, 32'h0000_0043, 32'h0, rd);  check("lw_43_split", rd, 32'h7766_5544);
      do_req(1'b1, 3'd2, 32'h0000_0041, 32'hDDCC_BBAA, rd);
      do_req(1'b0, 3'd4, 32'h0000_0044, 32'h0, rd);  check("lbu_44", rd, 32'h0000_00DD);
      do_req(1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0, rd);
`else
      do_req(1'b0, 3'd1, 32'h0000_0007, 32'h0, rd);  check("lh_07_err", rd, 32'h0);
      do_req(1'b1, 3'd2, 32'h0000_0042, 32'h1234_5678, rd);
`endif

      // Reset during the access cycle of a store
      @(negedge clk);
      bus.req_valid_i  = 1'b1;
      bus.req_we_i     = 1'b1;
      bus.req_funct3_i = 3'd2;
      bus.req_addr_i   = 32'h0000_0080;
      bus.req_wdata_i  = 32'hCAFE_F00D;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      check("acc1_we", 32'(bus.mem_we_o), 32'h1);
      rst_n = 1'b0;
      #1;
      check("midrst_we", 32'(bus.mem_we_o), 32'h0);
      check("midrst_mem", bus.mem_addr_o | bus.mem_wdata_o | 32'(bus.mem_transfer_o), 32'h0);
      check("midrst_ready", 32'(bus.req_ready_o), 32'h1);
      check("midrst_rdata", bus.rsp_rdata_o, 32'h0);
      last_rdata = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("postrst_novalid", 32'(bus.rsp_valid_o), 32'h0);
         check("postrst_ready", 32'(bus.req_ready_o), 32'h1);
      end
      do_req(1'b0, 3'd2, 32'h0000_0080, 32'h0, rd);

      for (int t = 0; t < 200; t++) begin
         logic [31:0] a;
         a = {(($urandom_range(0, 3) == 0) ? 24'hFF_FFFF : 24'($urandom)), 8'($urandom)};
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_WIDTH, 32, byte address width of request and memory ports SHALL be provided.
REQ-002 Parameter DATA_WIDTH, 32, word width SHALL be provided; only 32 is supported.
REQ-003 Parameter TRANSFER_WIDTH, 4, byte-strobe width (DATA_WIDTH/8) SHALL be provided.
REQ-004 Ports SHALL be:
 clk  in  1  clock
 rst_n  in  1  reset, asynchronous, active-low
 req_valid_i  in  1  core load/store request valid
 req_ready_o  out  1  unit can accept a request
 req_we_i  in  1  1=store, 0=load
 req_funct3_i  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
 req_addr_i  in  ADDR_WIDTH  byte address
 req_wdata_i  in  DATA_WIDTH  store data, LSB-aligned
 rsp_valid_o  out  1  one-cycle completion pulse
 rsp_rdata_o  out  DATA_WIDTH  extended load result
 rsp_err_o  out  1  misaligned or illegal funct3; qualified by rsp_valid_o
 mem_addr_o  out  ADDR_WIDTH  word-aligned address to data memory
 mem_we_o  out  1  memory write enable
 mem_wdata_o  out  DATA_WIDTH  lane-shifted write data
 mem_transfer_o  out  TRANSFER_WIDTH  byte write strobes
 mem_rdata_i  in  DATA_WIDTH  combinational memory read data, valid same cycle when mem_we_o=0

Function
REQ-005 FSM states SHALL be IDLE, ACC1, ACC2, RESP; req_ready_o=1 only in IDLE.
REQ-006 In IDLE, req_valid_i&req_ready_o SHALL register we, funct3, addr, wdata and move to ACC1, or to RESP with error flag if illegal/unsupported.
REQ-007 Illegal funct3: loads 3,6,7; stores >=3. SHALL produce rsp_err_o=1, no memory access.
REQ-008 ACC1 SHALL drive mem_addr_o=addr&~3, strobe=base_mask<<addr[1:0] truncated to 4 bits, mem_wdata_o=wdata<<(8*addr[1:0]); base_mask SB=0001, SH=0011, SW=1111.
REQ-009 mem_we_o SHALL be 1 only in ACC1/ACC2 for stores and never with mem_transfer_o=0 (memory treats zero strobe as full-word write).
REQ-010 Outside ACC1/ACC2, mem_we_o, mem_transfer_o, mem_addr_o, mem_wdata_o SHALL be 0.
REQ-011 Loads SHALL sample mem_rdata_i at end of ACC1 (and ACC2); result = word>>(8*addr[1:0]), sign-extended for LB/LH, zero-extended for LBU/LHU, unchanged for LW.
REQ-012 Misaligned: halfword with addr[1:0]=3; word with addr[1:0]!=0.
REQ-013 Aligned access SHALL go ACC1->RESP; request accepted cycle T gives rsp_valid_o at T+2.
REQ-014 RESP SHALL assert rsp_valid_o for exactly one cycle, then IDLE; next request acceptable in that IDLE cycle (throughput one per 3 cycles aligned).
REQ-015 rsp_rdata_o SHALL be 0 for stores and errored requests; held between responses.
REQ-016 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-017 rst_n low SHALL immediately force IDLE, req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, all mem_* outputs 0, including mid-access; the in-flight request is discarded without response.

Configuration
REQ-018 Macro LSU_MISALIGNED_SPLIT_EN SHALL select misaligned handling.
REQ-019 Defined: misaligned legal access SHALL run ACC1 (strobe/data per REQ-008, upper lanes dropped) then ACC2 at (addr&~3)+4 with strobe=(base_mask<<off)>>4, wdata>>(8*(4-off)); loads combine ACC1 bytes [31:8*off] low and ACC2 bytes high, then extend; rsp_valid_o at T+3, rsp_err_o=0.
REQ-020 Undefined: misaligned access SHALL skip memory, go IDLE->RESP, rsp_valid_o at T+1 with rsp_err_o=1; ACC2 not implemented.

Verification
REQ-021 SB addr 0x13 wdata 0xAB -> ACC1 mem_addr_o 0x10, strobe 1000, mem_wdata_o 0xAB000000, rsp at T+2 err 0.
REQ-022 Word 0x20=0x8000FF7F; LB 0x20 -> 0x0000007F; LB 0x21 -> 0xFFFFFFFF; LHU 0x22 -> 0x00008000; LH 0x22 -> 0xFFFF8000.
REQ-023 SPLIT_EN on: words 0x40=0x44332211, 0x44=0x88776655; LW 0x43 -> accesses 0x40 then 0x44, rsp 0x77665544 at T+3; SW 0x41 data 0xDDCCBBAA -> strobes 1110 then 0001, word 0x44 low byte 0xDD.
REQ-024 SPLIT_EN off: LH 0x07 -> no mem_we_o, zero strobes, rsp_valid_o at T+1 with rsp_err_o=1; funct3=3 load -> err=1.
REQ-025 rst_n low during ACC1 of SW -> mem_we_o drops same cycle, no rsp_valid_o, req_ready_o=1 after release.
